// File: rtl/frame_mux_pkg.sv
// frame_mux_pkg: shared FSM state type and round-robin pick helper for frame_mux_rr
package frame_mux_pkg;
  typedef enum logic {IDLE, LOCK} frm_state_t;
  localparam int MAX_CH = 16;
  function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req, input logic [3:0] last, input int n);
    logic [3:0] idx;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      idx = 4'((int'(last) + k) % n);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/frame_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_gnt
module rr_arbiter
  import frame_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_gnt,
  output logic [CH_W-1:0]   gnt,
  output logic              any_req
);
  assign gnt = CH_W'(rr_pick(MAX_CH'(req), 4'(last_gnt), NUM_CH));
  assign any_req = |req;
endmodule

// File: rtl/frame_mux_rr.sv
// frame_mux_rr: round-robin framed stream mux with frame-long grant lock and registered output
module frame_mux_rr
  import frame_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
  output logic                     busy
);
  frm_state_t state, state_n;
  logic [CH_W-1:0] gnt, last_gnt, arb_gnt;
  logic any_req, take, load;
  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req(in_valid),
    .last_gnt(last_gnt),
    .gnt(arb_gnt),
    .any_req(any_req)
  );
  assign take = state == LOCK && (!out_valid || out_ready);
  assign load = take && in_valid[gnt];
  assign in_ready = take ? NUM_CH'(1) << gnt : '0;
  assign busy = state == LOCK;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (any_req ? LOCK : IDLE) : (load && in_last[gnt] ? IDLE : LOCK);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      last_gnt  <= CH_W'(NUM_CH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) gnt <= arb_gnt;
      if (load && in_last[gnt]) last_gnt <= gnt;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gnt*DATA_W +: DATA_W];
        out_last  <= in_last[gnt];
        out_ch    <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frame_mux_rr.sv
// tb_frame_mux_rr: directed scoreboard bench with frame-rule monitors for frame_mux_rr
module tb_frame_mux_rr;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic out_valid, out_last, busy;
  logic out_ready = 1'b1;
  logic [1:0] out_ch;
  logic [15:0] d1 = '0;
  logic [15:0] od1;
  logic v1 = 1'b0;
  logic l1 = 1'b0;
  logic or1 = 1'b1;
  logic r1, ov1, ol1, b1;
  logic o_ch1;
  frame_mux_rr #(.NUM_CH(N), .DATA_W(W)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ch(out_ch), .out_ready(out_ready), .busy(busy)
  );
  frame_mux_rr #(.NUM_CH(1), .DATA_W(16)) u1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_last(l1),
    .in_ready(r1), .out_data(od1), .out_valid(ov1), .out_last(ol1),
    .out_ch(o_ch1), .out_ready(or1), .busy(b1)
  );
  typedef struct {int ch; int d; int l;} beat_t;
  beat_t exp_q[$];
  int xfer_cyc[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction
  logic p_v = 1'b0, p_r = 1'b0, p_rst = 1'b1, p_l = 1'b0, p_acc = 1'b0;
  logic [W-1:0] p_d = '0, p_acc_d = '0;
  int p_ch = 0, p_acc_ch = 0, open_ch = -1, ach;
  beat_t e;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_beat: got ch%0d data %0h, none expected", out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
      end
    end
    if (p_v && !p_r && !p_rst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, p_d);
      chk("hold_last", out_last, p_l);
      chk("hold_ch", out_ch, p_ch);
    end
    if (p_acc) begin
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, p_acc_d);
      chk("lat_ch", out_ch, p_acc_ch);
    end
    chk("ready_onehot", $onehot0(in_ready), 1);
    if (out_valid && !out_ready) chk("ready_blocked", in_ready, 0);
    p_acc = 1'b0;
    if (!rst && |(in_valid & in_ready)) begin
      for (int i = 0; i < N; i++) if (in_valid[i] && in_ready[i]) ach = i;
      if (open_ch >= 0) chk("no_interleave", ach, open_ch);
      open_ch = in_last[ach] ? -1 : ach;
      p_acc = 1'b1;
      p_acc_d = in_data[ach*W +: W];
      p_acc_ch = ach;
    end
    if (rst) open_ch = -1;
    p_v = out_valid;
    p_r = out_ready;
    p_rst = rst;
    p_d = out_data;
    p_l = out_last;
    p_ch = out_ch;
  end
  task automatic send(input int ch, input int d, input bit l);
    int t = 0;
    in_data[ch*W +: W] = W'(d);
    in_last[ch] = l;
    in_valid[ch] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[ch] && t < 200);
    if (!in_ready[ch]) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: ch%0d never got in_ready, required within 200 cycles", ch);
    end
    @(posedge clk);
    #1;
    in_valid[ch] = 1'b0;
    in_last[ch] = 1'b0;
  endtask
  task automatic send_frame(input int ch, input int base, input int n);
    for (int i = 0; i < n; i++) send(ch, base + i, i == n - 1);
  endtask
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int base;
    int t;
    in_data = 32'hC3C2C1C0;
    in_valid = '1;
    in_last = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_ch", out_ch, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 in_valid = 4'b0001;
    exp_q.push_back('{0, 'hC0, 1});
    @(negedge clk);
    chk("first_grant", in_ready, 4'b0001);
    chk("first_busy", busy, 1);
    @(posedge clk);
    #1;
    in_valid = '0;
    in_last = '0;
    settle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{i, 'hA0 + i, 1});
    base = xfer_cyc.size();
    fork
      send(0, 'hA0, 1);
      send(1, 'hA1, 1);
      send(2, 'hA2, 1);
      send(3, 'hA3, 1);
    join
    settle();
    for (int i = 1; i < 4; i++) chk("rr_gap", xfer_cyc[base+i] - xfer_cyc[base+i-1], 2);
    exp_q.push_back('{1, 'h11, 0});
    exp_q.push_back('{1, 'h12, 0});
    exp_q.push_back('{1, 'h13, 1});
    exp_q.push_back('{2, 'h21, 0});
    exp_q.push_back('{2, 'h22, 1});
    exp_q.push_back('{1, 'h14, 1});
    fork
      begin
        send_frame(1, 'h11, 3);
        send(1, 'h14, 1);
      end
      send_frame(2, 'h21, 2);
    join
    settle();
    for (int i = 0; i < 6; i++) exp_q.push_back('{2, 'h40 + i, i == 5});
    base = xfer_cyc.size();
    fork
      send_frame(2, 'h40, 6);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_ready", in_ready, 0);
          chk("bp_data", out_data, 'h41);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    settle();
    for (int i = 2; i < 6; i++) chk("bp_stream", xfer_cyc[base+i] - xfer_cyc[base+i-1], 1);
    exp_q.push_back('{3, 'h50, 0});
    exp_q.push_back('{3, 'h51, 0});
    send(3, 'h50, 0);
    send(3, 'h51, 0);
    in_data[3*W +: W] = 8'h52;
    in_valid[3] = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid[3] = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    exp_q.push_back('{0, 'h60, 1});
    exp_q.push_back('{3, 'h63, 1});
    fork
      send(0, 'h60, 1);
      send(3, 'h63, 1);
    join
    settle();
    d1 = 16'hBEEF;
    l1 = 1'b0;
    v1 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!r1 && t < 50);
    chk("n1_ready_beef", r1, 1);
    @(posedge clk);
    #1;
    d1 = 16'hCAFE;
    l1 = 1'b1;
    @(negedge clk);
    chk("n1_valid_beef", ov1, 1);
    chk("n1_data_beef", od1, 'hBEEF);
    chk("n1_last_beef", ol1, 0);
    chk("n1_ch_beef", o_ch1, 0);
    t = 0;
    while (!r1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("n1_ready_cafe", r1, 1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    l1 = 1'b0;
    @(negedge clk);
    chk("n1_valid_cafe", ov1, 1);
    chk("n1_data_cafe", od1, 'hCAFE);
    chk("n1_last_cafe", ol1, 1);
    chk("n1_ch_cafe", o_ch1, 0);
    @(negedge clk);
    chk("n1_drained", ov1, 0);
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_mux_rr.md
Name: frame_mux_rr

Overview:
- Parametrised N-channel successor to the 2:1 bit mux (MUX6).
- Merges NUM_CH framed byte streams, such as per-node CAN field streams, onto one output stream.
- Uses round-robin arbitration with a valid/ready handshake and a registered output stage.
- Grant is held for a whole frame, until the beat marked last, so frames never interleave.

Parameters:
- NUM_CH, 4: number of input channels, 1..16.
- DATA_W, 8: data width per beat, 1..64.
- CH_W, $clog2(NUM_CH) with a minimum of 1: width of the channel index (derived, localparam).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel beat valid.
- in_last  in  NUM_CH  per-channel end-of-frame marker, qualified by in_valid.
- in_ready  out  NUM_CH  per-channel accept; a beat transfers when in_valid[i] && in_ready[i].
- out_data  out  DATA_W  registered output beat.
- out_valid  out  1  output beat valid.
- out_last  out  1  output end-of-frame marker.
- out_ch  out  CH_W  source channel of the current output beat.
- out_ready  in  1  downstream accept; a beat transfers when out_valid && out_ready.
- busy  out  1  high while a frame is locked (state LOCK).

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, out_valid=0, out_data=0, out_last=0, out_ch=0, busy=0.
  - Round-robin pointer last_gnt=NUM_CH-1, so channel 0 has highest priority after reset.
  - rst overrides everything, including a frame mid-transfer. The partial frame is dropped with no flush and no last emitted. Upstream must restart the frame.
- State IDLE:
  - in_ready=0 for all channels.
  - If any in_valid is high, grant the first valid channel searching last_gnt+1, last_gnt+2, … modulo NUM_CH.
  - Register gnt and go to LOCK. Arbitration costs exactly 1 cycle.
  - If no in_valid is high, stay in IDLE.
- State LOCK:
  - busy=1.
  - in_ready[gnt] = (!out_valid || out_ready); all other in_ready bits are 0.
  - An accepted beat loads out_data, out_last and out_ch=gnt, and sets out_valid=1 on the next edge. Input-to-output latency is 1 cycle.
  - An accepted beat with in_last=1 sets last_gnt=gnt and returns to IDLE on the same edge.
- Output register:
  - If out_valid && out_ready and no new beat is loaded, out_valid clears to 0.
  - Simultaneous drain and load keeps out_valid=1 with the new beat. Full throughput is one beat per clock within a frame.
  - out_data, out_last and out_ch hold stable while out_valid && !out_ready (AXI-style stability).
- Idle output contents: out_data, out_last and out_ch keep their last values when out_valid=0; they are don't-care.
- Ordering rules:
  - Arbitration ignores in_valid of non-granted channels during LOCK; no preemption.
  - Inter-frame gap is at least 1 cycle (the IDLE arbitration cycle).
  - A single-beat frame (in_last on the first beat) is legal: IDLE → LOCK → IDLE.
- NUM_CH=1: the pointer is always 0, and behaviour otherwise follows the same rules.
- A granted channel may deassert in_valid mid-frame; the grant is held indefinitely (no timeout).

Decomposition:
- Package frame_mux_pkg holds:
  - typedef enum logic {IDLE, LOCK} frm_state_t;
  - a function rr_pick(req, last) returning the next index.
- Natural sub-module rr_arbiter, which is combinational: req[NUM_CH] and last_gnt in, gnt index and any_req out. It is reused by future multi-node CAN blocks.
- Output register and FSM stay in frame_mux_rr.

Test Plan:
1. Reset check: assert rst with all in_valid=1.
   - Required: out_valid=0, busy=0, in_ready=0, out_ch=0 during reset.
   - Required: first grant after release goes to ch0.
2. Round-robin: ch0..ch3 each present a 1-beat frame with data 0xA0..0xA3, last=1, out_ready=1.
   - Required output order: ch0, ch1, ch2, ch3 with data A0..A3.
   - Required: each beat appears 1 cycle after acceptance, with 1 IDLE cycle between frames.
3. Frame lock: ch1 sends 3 beats 0x11, 0x12, 0x13 (last on 0x13) while ch2 is valid throughout.
   - Required: no ch2 beat appears before 0x13.
   - Required: ch2 is granted next; ch1 is lowest priority afterwards.
4. Backpressure: out_ready=0 for 5 cycles during a frame.
   - Required: out_data stable, in_ready[gnt]=0 after the output register fills.
   - Required: no beat lost or duplicated.
   - Required: with out_ready=1, beats stream at 1 per clock.
5. Reset mid-frame: rst pulsed after beat 2 of a 4-beat ch3 frame.
   - Required: out_valid=0 next cycle, state IDLE, pointer reset, so ch0 wins the next arbitration.
6. NUM_CH=1, DATA_W=16: frame 0xBEEF, 0xCAFE (last).
   - Required output: BEEF then CAFE, out_ch=0, out_last only on CAFE.
